// File: rtl/vga_timing_core.sv
// vga_timing_core: 640x480@60 raster generator for the 50 MHz system clock.
// Divides clk down to the pixel rate, runs the h/v counters that upstream
// colour logic reads as (x, y), and registers sync/blank/colour one pixel
// period later so every field on the DAC bus stays aligned.
module vga_timing_core #(
  parameter int CLK_DIV  = 2,
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  r,
  input  logic [7:0]  g,
  input  logic [7:0]  b,
  output logic [9:0]  x,
  output logic [9:0]  y,
  output logic        frame_start,
  output logic        vblank,
  output logic [28:0] vga_output_data
);

  localparam int H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int HS_START = H_ACTIVE + H_FP;
  localparam int HS_END   = HS_START + H_SYNC;
  localparam int VS_START = V_ACTIVE + V_FP;
  localparam int VS_END   = VS_START + V_SYNC;
  localparam int DIV_W    = $clog2(CLK_DIV);

  // True when cnt lies in the half-open window [lo, hi).
  function automatic logic in_window(input logic [9:0] cnt, input int lo, input int hi);
    return (int'(cnt) >= lo) && (int'(cnt) < hi);
  endfunction

  logic [DIV_W-1:0] div_cnt_q, div_cnt_d;
  logic [9:0]       hcount_q, hcount_d;
  logic [9:0]       vcount_q, vcount_d;
  logic             hs_q, hs_d;
  logic             vs_q, vs_d;
  logic             blank_n_q, blank_n_d;
  logic [23:0]      rgb_q, rgb_d;
  logic             frame_start_q, frame_start_d;

  logic pix_en, vga_clk, h_last, v_last;
  logic active, hs_raw, vs_raw;

  // Divider phase, pixel strobe and raster decode of the current count.
  always_comb begin
    pix_en  = (div_cnt_q == DIV_W'(CLK_DIV - 1));
    vga_clk = (div_cnt_q >= DIV_W'(CLK_DIV / 2));
    h_last  = (hcount_q == 10'(H_TOTAL - 1));
    v_last  = (vcount_q == 10'(V_TOTAL - 1));
    active  = (int'(hcount_q) < H_ACTIVE) && (int'(vcount_q) < V_ACTIVE);
    hs_raw  = !in_window(hcount_q, HS_START, HS_END);
    vs_raw  = !in_window(vcount_q, VS_START, VS_END);
  end

  // Next state for the divider and the h/v counters; counters only move on pix_en.
  always_comb begin
    div_cnt_d = pix_en ? '0 : div_cnt_q + DIV_W'(1);
    hcount_d  = hcount_q;
    vcount_d  = vcount_q;
    if (pix_en) begin
      hcount_d = h_last ? 10'd0 : hcount_q + 10'd1;
      if (h_last) begin
        vcount_d = v_last ? 10'd0 : vcount_q + 10'd1;
      end
    end
  end

  // Output stage: capture the decode and gated colour once per pixel so the
  // DAC lags the counter by exactly one pixel period on every field.
  always_comb begin
    hs_d          = hs_q;
    vs_d          = vs_q;
    blank_n_d     = blank_n_q;
    rgb_d         = rgb_q;
    frame_start_d = pix_en && h_last && v_last;
    if (pix_en) begin
      hs_d      = hs_raw;
      vs_d      = vs_raw;
      blank_n_d = active;
      rgb_d     = active ? {r, g, b} : 24'h0;
    end
  end

  // State registers; reset parks the raster at (0,0) with syncs idle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      div_cnt_q     <= '0;
      hcount_q      <= 10'd0;
      vcount_q      <= 10'd0;
      hs_q          <= 1'b1;
      vs_q          <= 1'b1;
      blank_n_q     <= 1'b0;
      rgb_q         <= 24'h0;
      frame_start_q <= 1'b0;
    end else begin
      div_cnt_q     <= div_cnt_d;
      hcount_q      <= hcount_d;
      vcount_q      <= vcount_d;
      hs_q          <= hs_d;
      vs_q          <= vs_d;
      blank_n_q     <= blank_n_d;
      rgb_q         <= rgb_d;
      frame_start_q <= frame_start_d;
    end
  end

  assign x               = hcount_q;
  assign y               = vcount_q;
  assign frame_start     = frame_start_q;
  assign vblank          = (int'(vcount_q) >= V_ACTIVE);
  // Composite sync is not used by the DAC, so sync_n is tied low.
  assign vga_output_data = {vga_clk, blank_n_q, 1'b0, hs_q, vs_q, rgb_q};

endmodule

// File: tb/tb_vga_timing_core.sv
// Directed bench for vga_timing_core. Horizontal timing is the 640-pixel
// default; vertical timing is shrunk (4 active lines, 8 total) so whole
// frames are short. Sync lines sit at 5..6, vblank at lines 4..7.
module tb_vga_timing_core;

  localparam int V_ACT  = 4;
  localparam int V_FP   = 1;
  localparam int V_SYN  = 2;
  localparam int V_BP   = 1;
  localparam int LINE   = 1600;          // clks per line
  localparam int FRAME  = LINE * 8;      // clks per frame

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [7:0]  r   = 8'h00;
  logic [7:0]  g   = 8'hFF;
  logic [7:0]  b   = 8'hFF;
  logic [9:0]  x, y;
  logic        frame_start, vblank;
  logic [28:0] vga_output_data;

  int cyc    = 0;
  int n_chk  = 0;
  int n_fail = 0;
  int fs_cnt = 0;
  int xh0 = 0, xh1 = 0, xh2 = 0;
  int yh0 = 0, yh1 = 0, yh2 = 0;

  vga_timing_core #(
    .CLK_DIV (2),
    .H_ACTIVE(640), .H_FP(16), .H_SYNC(96), .H_BP(48),
    .V_ACTIVE(V_ACT), .V_FP(V_FP), .V_SYNC(V_SYN), .V_BP(V_BP)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .r              (r),
    .g              (g),
    .b              (b),
    .x              (x),
    .y              (y),
    .frame_start    (frame_start),
    .vblank         (vblank),
    .vga_output_data(vga_output_data)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input int got, input int exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Advance to the next falling edge, keep x/y history, drive r = x[7:0].
  task automatic tick();
    @(negedge clk);
    xh2 = xh1; xh1 = xh0; xh0 = int'(x);
    yh2 = yh1; yh1 = yh0; yh0 = int'(y);
    if (frame_start) fs_cnt++;
    r = x[7:0];
  endtask

  task automatic wait_until(input int tgt);
    while (cyc < tgt) tick();
  endtask

  task automatic wait_hs(input logic lvl, input int limit, output int tt);
    tt = -1;
    for (int i = 0; i < limit; i++) begin
      tick();
      if (vga_output_data[25] === lvl) begin
        tt = cyc;
        break;
      end
    end
    if (tt < 0) chk("hs_wait_timeout", 0, 1);
  endtask

  initial begin
    int rel, rel2, t_fall, t_rise, t, t1, fs_base, found;
    int vs_first, vs_low, vb_hi, vb_err, bl_cnt, mod_err, fs_n;
    int fs_t[2];
    logic vs_prev, act;
    logic [28:0] exp_bus;

    // Reset held for 5 clks
    repeat (5) tick();
    chk("rst_x", int'(x), 0);
    chk("rst_y", int'(y), 0);
    chk("rst_ctl", int'(vga_output_data[28:24]), 3);
    chk("rst_rgb", int'(vga_output_data[23:0]), 0);
    chk("rst_fs", int'(frame_start), 0);

    // Release and first pixel steps
    rst = 1'b1;
    rel = cyc;
    tick();
    chk("rel_x_e1", int'(x), 0);
    chk("rel_vgaclk_e1", int'(vga_output_data[28]), 1);
    tick();
    chk("rel_x_e2", int'(x), 1);
    wait_until(rel + 4);
    chk("rel_x_e4", int'(x), 2);

    // Line timing
    wait_hs(1'b0, 2000, t_fall);
    chk("hs_fall", t_fall - rel, 1314);
    wait_hs(1'b1, 400, t_rise);
    chk("hs_low_width", t_rise - t_fall, 192);
    wait_until(rel + 1598);
    chk("x_before_wrap", int'(x), 799);
    chk("y_before_wrap", int'(y), 0);
    wait_until(rel + 1600);
    chk("x_after_wrap", int'(x), 0);
    chk("y_after_wrap", int'(y), 1);
    wait_hs(1'b0, 2000, t);
    chk("hs_period", t - t_fall, 1600);

    // First frame wrap
    t1 = -1;
    for (int i = 0; i < FRAME + 200; i++) begin
      tick();
      if (frame_start) begin t1 = cyc; break; end
    end
    chk("fs_first", t1 - rel, FRAME);

    // Two full frames: timing, blanking gate and colour alignment
    vs_first = -1; vs_low = 0; vb_hi = 0; vb_err = 0;
    bl_cnt = 0; mod_err = 0; fs_n = 0; vs_prev = 1'b1;
    fs_t[0] = 0; fs_t[1] = 0;
    for (int i = 0; i < 2 * FRAME; i++) begin
      tick();
      if (frame_start) begin
        if (fs_n < 2) fs_t[fs_n] = cyc;
        fs_n++;
      end
      if (vblank) vb_hi++;
      if (vblank !== (int'(y) >= V_ACT)) vb_err++;
      if (!vga_output_data[24]) begin
        vs_low++;
        if (vs_prev && vs_first < 0) vs_first = cyc;
      end
      vs_prev = vga_output_data[24];
      if (vga_output_data[27]) bl_cnt++;
      act = (xh2 < 640) && (yh2 < V_ACT);
      exp_bus = {((cyc - rel) % 2 == 1), act, 1'b0,
                 !(xh2 >= 656 && xh2 < 752), !(yh2 >= 5 && yh2 < 7),
                 act ? {8'(xh2), 16'hFFFF} : 24'h0};
      if (vga_output_data !== exp_bus) mod_err++;
    end
    chk("fs_count", fs_n, 2);
    chk("fs_spacing_1", fs_t[0] - t1, FRAME);
    chk("fs_spacing_2", fs_t[1] - fs_t[0], FRAME);
    chk("vs_fall_offset", vs_first - t1, 5 * LINE + 2);
    chk("vs_low_clks", vs_low, 2 * 2 * LINE);
    chk("vblank_high_clks", vb_hi, 2 * 4 * LINE);
    chk("vblank_decode_errs", vb_err, 0);
    chk("blank_n_clks", bl_cnt, 2 * 640 * V_ACT * 2);
    chk("bus_model_errs", mod_err, 0);

    // Mid-frame reset inside an hs-low period
    found = 0;
    for (int i = 0; i < FRAME + 200; i++) begin
      tick();
      if (int'(y) == 2 && int'(x) == 700) begin found = 1; break; end
    end
    chk("mid_point_found", found, 1);
    chk("mid_hs_low", int'(vga_output_data[25]), 0);
    rst = 1'b0;
    #1;
    chk("mid_rst_ctl", int'(vga_output_data[28:24]), 3);
    chk("mid_rst_rgb", int'(vga_output_data[23:0]), 0);
    chk("mid_rst_xy", int'({y, x}), 0);
    repeat (3) tick();
    rst = 1'b1;
    rel2 = cyc;
    fs_base = fs_cnt;
    wait_hs(1'b0, 2000, t);
    chk("rst2_hs_fall", t - rel2, 1314);
    wait_until(rel2 + FRAME - 1);
    chk("rst2_fs_early", fs_cnt - fs_base, 0);
    tick();
    chk("rst2_fs_at_frame", int'(frame_start), 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
